// File: rtl/mips_defs_pkg.sv
// ============================================================================
//  mips_defs : shared definitions for the EX-stage multiply/divide unit
//  Revision  : 1.0
// ============================================================================
`default_nettype none

package mips_defs;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

endpackage

`default_nettype wire

// File: rtl/md_calc.sv
// ============================================================================
//  md_calc  : combinational multiply/divide datapath producing HI/LO results
//  Revision : 1.0
// ============================================================================
`default_nettype none

module md_calc
  import mips_defs::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo,
  output logic              dz
);

  logic [2*DATA_W-1:0] w_smul;
  logic [2*DATA_W-1:0] w_umul;
  logic [DATA_W-1:0]   w_b_safe;
  logic [DATA_W-1:0]   w_abs_a;
  logic [DATA_W-1:0]   w_abs_b;
  logic [DATA_W-1:0]   w_mag_q;
  logic [DATA_W-1:0]   w_mag_r;
  logic [DATA_W-1:0]   w_uq;
  logic [DATA_W-1:0]   w_ur;
  logic                w_b_zero;

  assign w_smul = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
  assign w_umul = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  // A zero divisor is replaced by 1 so the dividers never see zero; the
  // result is discarded by the sequencer in that case.
  assign w_b_zero = (b == '0);
  assign w_b_safe = w_b_zero ? {{(DATA_W-1){1'b0}}, 1'b1} : b;

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 r 0.
  assign w_abs_a = a[DATA_W-1] ? (~a + 1'b1) : a;
  assign w_abs_b = w_b_safe[DATA_W-1] ? (~w_b_safe + 1'b1) : w_b_safe;
  assign w_mag_q = w_abs_a / w_abs_b;
  assign w_mag_r = w_abs_a % w_abs_b;
  assign w_uq    = a / w_b_safe;
  assign w_ur    = a % w_b_safe;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    dz     = 1'b0;
    case (md_op_e'(op))
      MD_MULT: begin
        res_hi = w_smul[2*DATA_W-1:DATA_W];
        res_lo = w_smul[DATA_W-1:0];
      end
      MD_MULTU: begin
        res_hi = w_umul[2*DATA_W-1:DATA_W];
        res_lo = w_umul[DATA_W-1:0];
      end
      MD_DIV: begin
        res_lo = (a[DATA_W-1] ^ b[DATA_W-1]) ? (~w_mag_q + 1'b1) : w_mag_q;
        res_hi = a[DATA_W-1] ? (~w_mag_r + 1'b1) : w_mag_r;
        dz     = w_b_zero;
      end
      MD_DIVU: begin
        res_lo = w_uq;
        res_hi = w_ur;
        dz     = w_b_zero;
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
        dz     = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
//  md_unit  : multi-cycle multiply/divide sequencer owning the HI/LO registers
//  Revision : 1.0
// ============================================================================
`default_nettype none

module md_unit
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        md_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_zero
);

  localparam int C_MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int C_CNT_W = (C_MAX_N > 1) ? $clog2(C_MAX_N) : 1;
  localparam logic [C_CNT_W-1:0] C_MULT_LOAD = C_CNT_W'(MULT_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_DIV_LOAD  = C_CNT_W'(DIV_CYCLES - 1);

  logic              r_busy;
  logic [C_CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_pend_hi;
  logic [DATA_W-1:0] r_pend_lo;
  logic              r_pend_dz;
  logic              r_pend_div;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_div_zero;

  logic [DATA_W-1:0] w_res_hi;
  logic [DATA_W-1:0] w_res_lo;
  logic              w_dz;

  md_calc u_calc (
    .op     (md_op),
    .a      (a),
    .b      (b),
    .res_hi (w_res_hi),
    .res_lo (w_res_lo),
    .dz     (w_dz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy     <= 1'b0;
      r_cnt      <= '0;
      r_pend_hi  <= '0;
      r_pend_lo  <= '0;
      r_pend_dz  <= 1'b0;
      r_pend_div <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else if (r_busy) begin
      // Any start seen while busy, including on the commit edge, is dropped.
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
        if (r_pend_dz) begin
          r_div_zero <= 1'b1;
        end else begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
          if (r_pend_div) begin
            r_div_zero <= 1'b0;
          end
        end
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else if (start) begin
      case (md_op_e'(md_op))
        MD_MULT, MD_MULTU: begin
          r_busy     <= 1'b1;
          r_cnt      <= C_MULT_LOAD;
          r_pend_hi  <= w_res_hi;
          r_pend_lo  <= w_res_lo;
          r_pend_dz  <= 1'b0;
          r_pend_div <= 1'b0;
        end
        MD_DIV, MD_DIVU: begin
          r_busy     <= 1'b1;
          r_cnt      <= C_DIV_LOAD;
          r_pend_hi  <= w_res_hi;
          r_pend_lo  <= w_res_lo;
          r_pend_dz  <= w_dz;
          r_pend_div <= 1'b1;
        end
        MD_MTHI: r_hi <= a;
        MD_MTLO: r_lo <= a;
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
//  tb_md_unit : directed self-checking bench for md_unit
//  Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_md_unit;
  import mips_defs::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int checks;
  int failures;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues a one-cycle start and counts how many sampled cycles busy stays high.
  task automatic run_op(input logic [2:0] op, input logic [31:0] va,
                        input logic [31:0] vb, output int n);
    start = 1'b1; md_op = op; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; md_op = MD_NOP;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    checks = 0; failures = 0;
    reset = 1'b1; start = 1'b0; md_op = MD_NOP; a = '0; b = '0;

    vecs[0]  = '{MD_MULT,  32'd3,        32'hFFFFFFFE, 5,  32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{MD_DIVU,  32'd7,        32'd2,        10, 32'd1,        32'd3,        1'b0};
    vecs[4]  = '{MD_MTHI,  32'h11,       32'd0,        0,  32'h11,       32'd3,        1'b0};
    vecs[5]  = '{MD_MTLO,  32'h22,       32'd0,        0,  32'h11,       32'h22,       1'b0};
    vecs[6]  = '{MD_DIVU,  32'd7,        32'd0,        10, 32'h11,       32'h22,       1'b1};
    vecs[7]  = '{MD_DIV,   32'd8,        32'd2,        10, 32'd0,        32'd4,        1'b0};
    vecs[8]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'd0,        32'h80000000, 1'b0};
    vecs[9]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[10] = '{MD_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'd0,        1'b0};
    vecs[11] = '{MD_NOP,   32'd5,        32'd5,        0,  32'h40000000, 32'd0,        1'b0};
    vecs[12] = '{3'd7,     32'd5,        32'd5,        0,  32'h40000000, 32'd0,        1'b0};
    vecs[13] = '{MD_DIVU,  32'd1,        32'd0,        10, 32'h40000000, 32'd0,        1'b1};
    vecs[14] = '{MD_MULTU, 32'd2,        32'd3,        5,  32'd0,        32'd6,        1'b1};
    vecs[15] = '{MD_DIV,   32'hFFFFFFF8, 32'd3,        10, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_dz", {31'd0, div_zero}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      check($sformatf("v%0d_cycles", i), 32'(n), 32'(vecs[i].cycles));
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      check($sformatf("v%0d_dz", i), {31'd0, div_zero}, {31'd0, vecs[i].exp_dz});
    end

    // Starts presented while busy must be ignored.
    start = 1'b1; md_op = MD_MULT; a = 32'd5; b = 32'd6;
    @(negedge clk);
    n = busy ? 1 : 0;
    start = 1'b1; md_op = MD_MTHI; a = 32'hAAAA;
    @(negedge clk);
    if (busy) n++;
    md_op = MD_MULT; a = 32'd9; b = 32'd9;
    @(negedge clk);
    if (busy) n++;
    start = 1'b0; md_op = MD_NOP;
    while (busy && n < 100) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("ign_cycles", 32'(n), 32'd5);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd30);

    run_op(MD_MTLO, 32'h55, 32'd0, n);
    check("mtlo_busy", 32'(n), 32'd0);
    check("mtlo_lo", lo, 32'h55);
    check("mtlo_hi", hi, 32'd0);

    // Start on the commit edge is dropped; the following cycle is accepted.
    start = 1'b1; md_op = MD_MULTU; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0; md_op = MD_NOP;
    repeat (4) @(negedge clk);
    check("b2b_busy_pre", {31'd0, busy}, 32'd1);
    start = 1'b1; md_op = MD_MTHI; a = 32'h77;
    @(negedge clk);
    check("b2b_busy_post", {31'd0, busy}, 32'd0);
    check("b2b_hi_commit", hi, 32'd0);
    check("b2b_lo_commit", lo, 32'd4);
    @(negedge clk);
    start = 1'b0; md_op = MD_NOP;
    check("b2b_hi_next", hi, 32'h77);

    // Reset in mid-divide discards the pending result.
    run_op(MD_DIVU, 32'd9, 32'd0, n);
    check("pre_rst_dz", {31'd0, div_zero}, 32'd1);
    start = 1'b1; md_op = MD_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; md_op = MD_NOP;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("rst_quiet%0d", i), {busy, hi[30:0]} | lo, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage. Consumes the post-forwarding rs/rt operand values selected by the EX forward muxes (forward_a_ex/forward_b_ex).
- Owns the HI/LO architectural registers.
- Drives busy into the hazard unit, which stalls any ID-stage MULT/DIV/MFHI/MFLO/MTHI/MTLO while busy or start is high.

Parameters:
- MULT_CYCLES, 5, cycles from start to HI/LO commit for MULT/MULTU (>=1).
- DIV_CYCLES, 10, cycles from start to HI/LO commit for DIV/DIVU (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  EX instruction is a valid md op this cycle; sampled on clk rising edge.
- md_op  input  3  operation code (encoding in package).
- a  input  32  forwarded rs value.
- b  input  32  forwarded rt value.
- busy  output  1  operation in flight, registered.
- hi  output  32  HI register, registered.
- lo  output  32  LO register, registered.
- div_zero  output  1  sticky flag: last DIV/DIVU had b==0; registered.

Behaviour:
- Reset: busy=0, hi=0, lo=0, div_zero=0, counter=0, pending result regs=0. Reset wins over every other event, including mid-operation; the in-flight result is discarded.
- Accept: start=1 at edge k with busy=0 and md_op in {MULT, MULTU, DIV, DIVU}:
  - a and b are latched.
  - Result is computed into pending_hi/pending_lo.
  - Counter is loaded with N-1, where N = MULT_CYCLES or DIV_CYCLES.
  - busy=1 after edge k.
- Count: while busy, counter decrements each edge. At the edge where counter==0: hi/lo <= pending, busy <= 0. busy is therefore high for exactly N cycles, and the new HI/LO is visible the cycle after busy falls.
- MULT: signed 32x32 to 64 bits; hi=[63:32], lo=[31:0].
- MULTU: unsigned 32x32 to 64 bits; hi=[63:32], lo=[31:0].
- DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
- DIVU: unsigned; lo=quotient, hi=remainder.
- Divide by zero (b==0):
  - Timing is unchanged; busy still lasts DIV_CYCLES.
  - At the commit edge, hi/lo are NOT written and div_zero<=1.
  - Any nonzero-divisor DIV/DIVU commit clears div_zero.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI / MTLO: start=1 with busy=0 writes hi<=a (or lo<=a) at that edge. busy is not set, so latency is 1 cycle.
- start=1 while busy=1: ignored, with no state change. The hazard unit guarantees this never occurs; the bench checks the ignore anyway.
- md_op NOP or any undefined code with start=1: ignored.
- Back-to-back: start at the same edge where the previous op commits is ignored, because busy is still 1 at that edge. The next start is accepted one cycle later.
- hi/lo change only at a commit edge, an MTHI/MTLO edge, or reset.
- Combinational reads in MFHI/MFLO paths use the hi/lo outputs directly.

Decomposition:
- Shared package mips_defs:
  - md_op encoding: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - Data width constant: 32.
- One sub-module, md_calc: purely combinational.
  - Inputs: op, a, b.
  - Outputs: res_hi, res_lo, dz.
  - Keeps the arithmetic separate from the sequencing FSM (IDLE/BUSY encoded by busy + counter).

Test Plan:
- MULT a=3, b=0xFFFFFFFE -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7, b=2 -> lo=3, hi=1.
- DIVU a=7, b=0 with prior hi=0x11, lo=0x22 -> busy 10 cycles; hi=0x11, lo=0x22 unchanged; div_zero=1. A following DIV 8/2 clears div_zero; lo=4, hi=0.
- MULT accepted; at busy cycle 2 assert MTHI a=0xAAAA and start=MULT a=9, b=9 -> both ignored; commit yields the original MULT result. MTLO a=0x55 after busy falls -> lo=0x55 next cycle, busy stays 0.
- DIV started; reset asserted on busy cycle 4 -> next cycle busy=0, hi=0, lo=0, div_zero=0; no late commit occurs over the following 10 cycles.
